instr_encoder: RTL and testbench

- Converts field-level instruction commands into 32-bit RV32I machine words for the five opcode classes the core's main decoder supports: lw, sw, R-type, beq, addi.
- Writes the words sequentially into instruction memory.
- Sits between the test/boot command source and the instruction-memory write port, so programs can be loaded without a precompiled hex image.
- Valid/ready handshake on input; single-stage registered output with backpressure; sticky error reporting.

---
 rtl/instr_encoder.sv | 116 +++++++++++
 tb/tb_instr_encoder.sv | 328 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_encoder.sv
// Field-level command to RV32I word encoder for lw/sw/R-type/beq/addi,
// streaming encoded words sequentially into instruction memory.
module instr_encoder #(
  parameter int ADDR_W = 10,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        in_kind,
  input  logic [2:0]        in_funct3,
  input  logic              in_f7b5,
  input  logic [4:0]        in_rd,
  input  logic [4:0]        in_rs1,
  input  logic [4:0]        in_rs2,
  input  logic [12:0]       in_imm,
  output logic              wr_en,
  input  logic              wr_ready,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [31:0]       wr_data,
  output logic              full,
  output logic              err,
  output logic [1:0]        err_code
);

  localparam logic [ADDR_W-1:0] LAST = '1;

  logic is_lw, is_sw, is_r, is_beq, is_addi;
  logic illegal, range_bad, odd;
  logic at_last, accept, done;
  logic [1:0] chk;
  logic [31:0] word;

  assign is_lw   = in_kind == 3'd0;
  assign is_sw   = in_kind == 3'd1;
  assign is_r    = in_kind == 3'd2;
  assign is_beq  = in_kind == 3'd3;
  assign is_addi = in_kind == 3'd4;

  assign illegal = (in_kind > 3'd4) ||
    (is_r && in_f7b5 &&
     in_funct3 != 3'b000 && in_funct3 != 3'b101);
  assign range_bad = !is_beq && (in_imm[12] != in_imm[11]);
  assign odd = is_beq && in_imm[0];

  always_comb begin
    chk = 2'b00;
    if (illegal)        chk = 2'b01;
    else if (range_bad) chk = 2'b10;
    else if (odd)       chk = 2'b11;
  end

  always_comb begin
    word = '0;
    unique case (1'b1)
      is_lw:
        word = {in_imm[11:0], in_rs1, 3'b010,
                in_rd, 7'b0000011};
      is_sw:
        word = {in_imm[11:5], in_rs2, in_rs1, 3'b010,
                in_imm[4:0], 7'b0100011};
      is_r:
        word = {1'b0, in_f7b5, 5'b00000, in_rs2, in_rs1,
                in_funct3, in_rd, 7'b0110011};
      is_beq:
        word = {in_imm[12], in_imm[10:5], in_rs2, in_rs1,
                3'b000, in_imm[4:1], in_imm[11], 7'b1100011};
      is_addi:
        word = {in_imm[11:0], in_rs1, 3'b000,
                in_rd, 7'b0010011};
      default: word = '0;
    endcase
  end

  // A word pending at the last address must not be overtaken by a new one.
  assign at_last  = wr_addr == LAST;
  assign in_ready = !full && !clr &&
                    (!wr_en || (wr_ready && !at_last));
  assign accept   = in_valid && in_ready;
  assign done     = wr_en && wr_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_en    <= 1'b0;
      wr_addr  <= BASE_ADDR;
      wr_data  <= '0;
      full     <= 1'b0;
      err      <= 1'b0;
      err_code <= 2'b00;
    end else if (clr) begin
      wr_en    <= 1'b0;
      wr_addr  <= BASE_ADDR;
      full     <= 1'b0;
      err      <= 1'b0;
      err_code <= 2'b00;
    end else begin
      if (done) begin
        wr_en <= 1'b0;
        if (at_last) full <= 1'b1;
        else wr_addr <= wr_addr + 1'b1;
      end
      if (accept) begin
        if (chk != 2'b00) begin
          err <= 1'b1;
          if (!err) err_code <= chk;
        end else begin
          wr_en   <= 1'b1;
          wr_data <= word;
        end
      end
    end
  end

endmodule

// File: tb/tb_instr_encoder.sv
// Scoreboard bench for instr_encoder: directed scenarios plus
// randomized commands checked against an arithmetic reference model.
module tb_instr_encoder;

  localparam int AW = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic clr = 1'b0;
  logic in_valid = 1'b0;
  logic in_ready;
  logic [2:0] in_kind = '0;
  logic [2:0] in_funct3 = '0;
  logic in_f7b5 = 1'b0;
  logic [4:0] in_rd = '0;
  logic [4:0] in_rs1 = '0;
  logic [4:0] in_rs2 = '0;
  logic [12:0] in_imm = '0;
  logic wr_en;
  logic wr_ready = 1'b1;
  logic [AW-1:0] wr_addr;
  logic [31:0] wr_data;
  logic full;
  logic err;
  logic [1:0] err_code;

  always #5 clk = ~clk;

  instr_encoder #(.ADDR_W(AW), .BASE_ADDR(2'd0)) dut (
    .clk(clk), .rst_n(rst_n), .clr(clr),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_kind(in_kind), .in_funct3(in_funct3),
    .in_f7b5(in_f7b5), .in_rd(in_rd),
    .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm),
    .wr_en(wr_en), .wr_ready(wr_ready),
    .wr_addr(wr_addr), .wr_data(wr_data),
    .full(full), .err(err), .err_code(err_code)
  );

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [31:0]   data;
  } wr_t;

  wr_t exp_q[$];
  int checks = 0;
  int passed = 0;
  int words = 0;
  logic m_err = 1'b0;
  logic [1:0] m_code = 2'b00;
  logic auto_rdy = 1'b0;

  function automatic void check32(string name, logic [31:0] act,
                                  logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h want %h", name, act, exp);
  endfunction

  function automatic void check1(string name, logic act, logic exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %b want %b", name, act, exp);
  endfunction

  // Reference encoding built from field positions with plain arithmetic.
  function automatic logic [31:0] ref_word(int kind, int f3, int f7,
      int rd, int rs1, int rs2, int imm);
    logic [31:0] i = 32'(imm);
    logic [31:0] u = i & 32'hfff;
    logic [31:0] b = i & 32'h1fff;
    logic [31:0] r1 = 32'(rs1) << 15;
    logic [31:0] r2 = 32'(rs2) << 20;
    logic [31:0] d = 32'(rd) << 7;
    case (kind)
      0: return (u << 20) | r1 | (32'd2 << 12) | d | 32'd3;
      1: return ((u >> 5) << 25) | r2 | r1 | (32'd2 << 12) |
                ((u & 32'd31) << 7) | 32'd35;
      2: return (32'(f7) << 30) | r2 | r1 | (32'(f3) << 12) |
                d | 32'd51;
      3: return ((b >> 12) << 31) | (((b >> 5) & 32'd63) << 25) |
                r2 | r1 | (((b >> 1) & 32'd15) << 8) |
                (((b >> 11) & 32'd1) << 7) | 32'd99;
      default: return (u << 20) | r1 | d | 32'd19;
    endcase
  endfunction

  function automatic logic [1:0] ref_err(int kind, int f3, int f7,
                                         int imm);
    if (kind > 4 || (kind == 2 && f7 == 1 && f3 != 0 && f3 != 5))
      return 2'd1;
    if (kind != 3 && (imm < -2048 || imm > 2047)) return 2'd2;
    if (kind == 3 && (imm % 2) != 0) return 2'd3;
    return 2'd0;
  endfunction

  function automatic void model_clear();
    exp_q.delete();
    words = 0;
    m_err = 1'b0;
    m_code = 2'b00;
  endfunction

  task automatic send(input int kind, input int f3, input int f7,
      input int rd, input int rs1, input int rs2, input int imm,
      input bit exp_acc);
    bit acc = 0;
    logic [1:0] e;
    in_kind = 3'(kind);
    in_funct3 = 3'(f3);
    in_f7b5 = 1'(f7);
    in_rd = 5'(rd);
    in_rs1 = 5'(rs1);
    in_rs2 = 5'(rs2);
    in_imm = 13'(imm);
    in_valid = 1'b1;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (in_ready) begin
        acc = 1;
        break;
      end
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    check1("accept", acc, exp_acc);
    if (acc) begin
      e = ref_err(kind, f3, f7, imm);
      if (e != 2'd0) begin
        if (!m_err) m_code = e;
        m_err = 1'b1;
      end else begin
        exp_q.push_back('{addr: AW'(words),
          data: ref_word(kind, f3, f7, rd, rs1, rs2, imm)});
        words++;
      end
      check1("err", err, m_err);
      check32("err_code", 32'(err_code), 32'(m_code));
    end
  endtask

  task automatic drain();
    int n = 0;
    while ((exp_q.size() != 0 || wr_en) && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    check1("drain_done", n < 100, 1'b1);
  endtask

  task automatic do_clr();
    clr = 1'b1;
    @(posedge clk);
    #1;
    clr = 1'b0;
    model_clear();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_clear();
  endtask

  task automatic send_rand();
    int kind, f3, f7, imm;
    kind = ($urandom_range(0, 9) == 0) ? int'($urandom_range(5, 7))
                                        : int'($urandom_range(0, 4));
    f3 = int'($urandom_range(0, 7));
    f7 = ($urandom_range(0, 2) == 0) ? 1 : 0;
    if ($urandom_range(0, 9) == 0) imm = int'($urandom_range(0, 8191)) - 4096;
    else imm = int'($urandom_range(0, 4095)) - 2048;
    if (kind == 3 && $urandom_range(0, 4) != 0) imm = imm & ~1;
    send(kind, f3, f7, int'($urandom_range(0, 31)),
         int'($urandom_range(0, 31)), int'($urandom_range(0, 31)),
         imm, 1'b1);
  endtask

  // Monitor: compares every completed write against the scoreboard
  // and checks that a stalled word is held unchanged.
  initial begin
    logic held = 1'b0;
    logic [31:0] h_data = '0;
    logic [AW-1:0] h_addr = '0;
    wr_t e;
    forever begin
      @(negedge clk);
      if (rst_n && !clr && wr_en) begin
        if (held) begin
          check32("hold_data", wr_data, h_data);
          check32("hold_addr", 32'(wr_addr), 32'(h_addr));
        end
        if (wr_ready) begin
          held = 1'b0;
          if (exp_q.size() == 0) begin
            checks++;
            $display("FAIL unexpected_write: got %h @%0d want none",
                     wr_data, wr_addr);
          end else begin
            e = exp_q.pop_front();
            check32("wr_addr", 32'(wr_addr), 32'(e.addr));
            check32("wr_data", wr_data, e.data);
          end
        end else begin
          held = 1'b1;
          h_data = wr_data;
          h_addr = wr_addr;
        end
      end else begin
        held = 1'b0;
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (auto_rdy) wr_ready = ($urandom_range(0, 3) != 0);
    end
  end

  initial begin
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    check1("rst_wr_en", wr_en, 1'b0);
    check32("rst_addr", 32'(wr_addr), 32'd0);
    check32("rst_data", wr_data, 32'd0);
    check1("rst_full", full, 1'b0);
    check1("rst_err", err, 1'b0);
    check32("rst_code", 32'(err_code), 32'd0);
    check1("rst_ready", in_ready, 1'b1);

    send(4, 0, 0, 1, 0, 0, 5, 1'b1);
    check1("addi_wr_en", wr_en, 1'b1);
    check32("addi_addr", 32'(wr_addr), 32'd0);
    check32("addi_data", wr_data, 32'h00500093);
    drain();
    do_clr();

    send(2, 0, 1, 3, 1, 2, 0, 1'b1);
    check32("r_data", wr_data, 32'h402081B3);
    send(1, 0, 0, 0, 1, 2, 8, 1'b1);
    check32("sw_data", wr_data, 32'h0020A423);
    send(0, 0, 0, 5, 6, 0, 4, 1'b1);
    check32("lw_data", wr_data, 32'h00432283);
    drain();
    do_clr();

    wr_ready = 1'b0;
    send(3, 0, 0, 0, 1, 2, -4, 1'b1);
    check32("beq_data", wr_data, 32'hFE208EE3);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check1("stall_ready", in_ready, 1'b0);
      check1("stall_wr_en", wr_en, 1'b1);
    end
    @(posedge clk);
    #1;
    wr_ready = 1'b1;
    drain();
    do_clr();

    send(4, 0, 0, 1, 0, 0, 2048, 1'b1);
    check1("range_no_wr", wr_en, 1'b0);
    check32("range_code", 32'(err_code), 32'd2);
    send(6, 0, 0, 1, 0, 0, 0, 1'b1);
    check32("sticky_code", 32'(err_code), 32'd2);
    do_clr();
    check1("clr_err", err, 1'b0);
    check32("clr_addr", 32'(wr_addr), 32'd0);
    send(3, 0, 0, 0, 1, 2, 3, 1'b1);
    check32("odd_code", 32'(err_code), 32'd3);
    check1("odd_no_wr", wr_en, 1'b0);
    do_clr();

    wr_ready = 1'b0;
    send(4, 0, 0, 2, 3, 0, -7, 1'b1);
    in_valid = 1'b1;
    clr = 1'b1;
    @(negedge clk);
    check1("clr_blocks_ready", in_ready, 1'b0);
    @(posedge clk);
    #1;
    clr = 1'b0;
    in_valid = 1'b0;
    model_clear();
    check1("clr_drop", wr_en, 1'b0);
    wr_ready = 1'b1;

    for (int i = 0; i < 4; i++) send(4, 0, 0, i, i, 0, i * 3, 1'b1);
    send(0, 0, 0, 9, 9, 0, 16, 1'b0);
    drain();
    check1("full_set", full, 1'b1);
    check32("full_addr", 32'(wr_addr), 32'd3);
    do_reset();
    check1("rst2_full", full, 1'b0);
    check32("rst2_addr", 32'(wr_addr), 32'd0);

    auto_rdy = 1'b1;
    for (int i = 0; i < 400; i++) begin
      if (words == 4) begin
        drain();
        check1("rand_full", full, 1'b1);
        do_clr();
      end else if ($urandom_range(0, 49) == 0) begin
        do_clr();
      end else if ($urandom_range(0, 99) == 0) begin
        do_reset();
      end
      send_rand();
    end
    drain();
    check1("rand_end_full", full, words == 4);
    auto_rdy = 1'b0;
    #1;
    wr_ready = 1'b1;

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
